// File: rtl/wfg_drive_spi_mc.sv
// wfg_drive_spi_mc: multi chip-select SPI master drive core.
// Buffers AXIS samples in a FIFO; each pattern sync shifts one frame out.
// Ports: clk/rst_n; wfg_axis_* sample sink (tlast ignored); wfg_pat_sync_i
// trigger; ctrl_en/clkcfg_div/cfg_* settings, latched into shadow registers
// when a frame starts; wfg_drive_spi_* pads; status_* busy/fill/underflow.
// Optional: define WFG_DRIVE_SPI_MC_BURST_EN to add cfg_burst_q_i, which
// chains queued frames under one chip-select assertion.
module wfg_drive_spi_mc #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int NUM_CS          = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wfg_pat_sync_i,
  output logic                          wfg_axis_tready_o,
  input  logic                          wfg_axis_tvalid_i,
  input  logic [AXIS_DATA_WIDTH-1:0]    wfg_axis_tdata_i,
  input  logic                          wfg_axis_tlast_i,
  input  logic                          ctrl_en_q_i,
  input  logic [7:0]                    clkcfg_div_q_i,
  input  logic                          cfg_cpol_q_i,
  input  logic                          cfg_cpha_q_i,
  input  logic                          cfg_lsbfirst_q_i,
  input  logic [1:0]                    cfg_dff_q_i,
  input  logic                          cfg_sspol_q_i,
  input  logic [2:0]                    cfg_cs_sel_q_i,
`ifdef WFG_DRIVE_SPI_MC_BURST_EN
  input  logic                          cfg_burst_q_i,
`endif
  input  logic                          status_clr_i,
  output logic                          wfg_drive_spi_sclk_o,
  output logic [NUM_CS-1:0]             wfg_drive_spi_cs_no,
  output logic                          wfg_drive_spi_sdo_o,
  output logic                          status_busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   status_fill_o,
  output logic                          status_uflow_o
);
  localparam int W  = AXIS_DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LP_FULL = FIFO_DEPTH[AW:0];
  localparam logic [5:0]  LP_WN   = W[5:0];

  typedef enum logic [1:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_HOLD
  } state_t;

  state_t r_state, w_next;

  logic [W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_fill;
  logic          r_cpol, r_cpha, r_lsb, r_sspol;
  logic [2:0]    r_cs;
  logic [7:0]    r_div, r_hcnt;
  logic [5:0]    r_n;
  logic [6:0]    r_tog;
  logic [W-1:0]  r_sr;
  logic          r_sclk, r_sdo, r_uflow;

  logic          w_idle, w_full, w_empty, w_push;
  logic          w_start, w_load, w_abort, w_burst;
  logic          w_hend, w_last, w_adv;
  logic          w_lsb_sel, w_cpha_sel, w_unused;
  logic [5:0]    w_n_cfg, w_n_sel;
  logic [W-1:0]  w_mask, w_frame, w_algn;

  function automatic logic f_head(logic [W-1:0] v, logic lsb);
    return lsb ? v[0] : v[W-1];
  endfunction

  function automatic logic [W-1:0] f_shift(logic [W-1:0] v, logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  assign w_unused = wfg_axis_tlast_i;

  assign w_idle  = (r_state == S_IDLE);
  assign w_full  = (r_fill == LP_FULL);
  assign w_empty = (r_fill == '0);
  assign w_push  = wfg_axis_tvalid_i & wfg_axis_tready_o;
  assign w_start = w_idle & wfg_pat_sync_i
                 & ctrl_en_q_i & ~w_empty;
  assign w_abort = ~w_idle & ~ctrl_en_q_i;
  assign w_hend  = (r_hcnt == r_div);
  assign w_last  = (r_tog == {r_n, 1'b0} - 7'd1);
  // cpha=1 moves data on leading (odd) toggles, cpha=0 on
  // trailing ones except the final edge of the frame.
  assign w_adv   = r_cpha ? ~r_tog[0]
                          : (r_tog[0] & ~w_last);

`ifdef WFG_DRIVE_SPI_MC_BURST_EN
  assign w_burst = cfg_burst_q_i & ~w_empty;
`else
  assign w_burst = 1'b0;
`endif

  // Frame length 8*(dff+1), clamped to the stream width.
  always_comb begin
    w_n_cfg = {1'b0, cfg_dff_q_i, 3'b000} + 6'd8;
    if (W < 32 && w_n_cfg > LP_WN) w_n_cfg = LP_WN;
  end

  // A burst reload reuses the shadowed format.
  assign w_n_sel    = w_idle ? w_n_cfg : r_n;
  assign w_lsb_sel  = w_idle ? cfg_lsbfirst_q_i : r_lsb;
  assign w_cpha_sel = w_idle ? cfg_cpha_q_i : r_cpha;

  // MSB-first frames are left-aligned so the head is bit W-1.
  always_comb begin
    w_mask  = ~({W{1'b1}} << w_n_sel);
    w_frame = r_mem[r_rptr] & w_mask;
    w_algn  = w_lsb_sel ? w_frame
                        : (w_frame << (W - int'(w_n_sel)));
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = S_SETUP;
          w_load = 1'b1;
        end
      end
      S_SETUP: if (w_hend) w_next = S_SHIFT;
      S_SHIFT: if (w_hend && w_last) w_next = S_HOLD;
      S_HOLD: begin
        if (w_hend) begin
          if (w_burst) begin
            w_next = S_SETUP;
            w_load = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_next = S_IDLE;
      w_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else if (w_abort) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= wfg_axis_tdata_i;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_load) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_load})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_lsb   <= 1'b0;
      r_sspol <= 1'b0;
      r_cs    <= '0;
      r_div   <= '0;
      r_n     <= '0;
      r_sr    <= '0;
      r_sclk  <= 1'b0;
      r_sdo   <= 1'b0;
      r_hcnt  <= '0;
      r_tog   <= '0;
    end else begin
      if (w_load) begin
        if (w_idle) begin
          r_cpol  <= cfg_cpol_q_i;
          r_cpha  <= cfg_cpha_q_i;
          r_lsb   <= cfg_lsbfirst_q_i;
          r_sspol <= cfg_sspol_q_i;
          r_cs    <= cfg_cs_sel_q_i;
          r_div   <= clkcfg_div_q_i;
          r_n     <= w_n_cfg;
          r_sclk  <= cfg_cpol_q_i;
        end
        r_hcnt <= '0;
        r_tog  <= '0;
        if (w_cpha_sel) begin
          r_sdo <= 1'b0;
          r_sr  <= w_algn;
        end else begin
          r_sdo <= f_head(w_algn, w_lsb_sel);
          r_sr  <= f_shift(w_algn, w_lsb_sel);
        end
      end else if (!w_idle) begin
        r_hcnt <= w_hend ? '0 : r_hcnt + 8'd1;
        if (r_state == S_SHIFT && w_hend) begin
          r_sclk <= ~r_sclk;
          r_tog  <= r_tog + 7'd1;
          if (w_adv) begin
            r_sdo <= f_head(r_sr, r_lsb);
            r_sr  <= f_shift(r_sr, r_lsb);
          end
        end
      end
      if (w_next == S_IDLE) r_sdo <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_uflow <= 1'b0;
    else if (status_clr_i) r_uflow <= 1'b0;
    else if (w_idle && wfg_pat_sync_i
             && ctrl_en_q_i && w_empty)
      r_uflow <= 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_CS; i++) begin
      if (w_idle)
        wfg_drive_spi_cs_no[i] = ~cfg_sspol_q_i;
      else if (int'(r_cs) == i)
        wfg_drive_spi_cs_no[i] = r_sspol;
      else
        wfg_drive_spi_cs_no[i] = ~r_sspol;
    end
  end

  assign wfg_axis_tready_o    = ctrl_en_q_i & ~w_full;
  assign wfg_drive_spi_sclk_o = w_idle ? cfg_cpol_q_i : r_sclk;
  assign wfg_drive_spi_sdo_o  = r_sdo;
  assign status_busy_o        = ~w_idle;
  assign status_fill_o        = r_fill;
  assign status_uflow_o       = r_uflow;
endmodule

// File: tb/tb_wfg_drive_spi_mc.sv
// tb_wfg_drive_spi_mc: self-checking bench for wfg_drive_spi_mc.
// Vector table plus hand sequences; an SPI slave monitor feeds a scoreboard.
module tb_wfg_drive_spi_mc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sync = 1'b0;
  logic        tready;
  logic        tvalid = 1'b0;
  logic [31:0] tdata = '0;
  logic        tlast = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  div = '0;
  logic        cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
  logic [1:0]  dff = '0;
  logic        sspol = 1'b0;
  logic [2:0]  cs_sel = '0;
  logic        clr = 1'b0;
  logic        sclk, sdo, busy, uflow;
  logic [3:0]  cs_no;
  logic [2:0]  fill;

  always #5 clk = ~clk;

  wfg_drive_spi_mc #(
    .AXIS_DATA_WIDTH(32), .NUM_CS(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wfg_pat_sync_i(sync),
    .wfg_axis_tready_o(tready),
    .wfg_axis_tvalid_i(tvalid),
    .wfg_axis_tdata_i(tdata),
    .wfg_axis_tlast_i(tlast),
    .ctrl_en_q_i(en),
    .clkcfg_div_q_i(div),
    .cfg_cpol_q_i(cpol),
    .cfg_cpha_q_i(cpha),
    .cfg_lsbfirst_q_i(lsb),
    .cfg_dff_q_i(dff),
    .cfg_sspol_q_i(sspol),
    .cfg_cs_sel_q_i(cs_sel),
    .status_clr_i(clr),
    .wfg_drive_spi_sclk_o(sclk),
    .wfg_drive_spi_cs_no(cs_no),
    .wfg_drive_spi_sdo_o(sdo),
    .status_busy_o(busy),
    .status_fill_o(fill),
    .status_uflow_o(uflow)
  );

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          cyc;
    logic [3:0]  cs;
    logic        cpha;
  } frame_t;

  typedef struct {
    logic        cpol, cpha, lsb;
    logic [1:0]  dff;
    logic [7:0]  div;
    logic        sspol;
    logic [2:0]  cs;
    logic [31:0] data;
  } vec_t;

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_err = 0;
  bit     skip_next = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               nm, act, exp);
    end
  endtask

  // Reference model of one frame as a slave sees it.
  function automatic frame_t mk_frame(
      logic [31:0] d, logic [1:0] f, logic [7:0] dv,
      logic l, logic pol, logic [2:0] s, logic ph);
    frame_t      fr;
    int          n;
    logic [31:0] m;
    n = 8 * (int'(f) + 1);
    m = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    d = d & m;
    fr.bits = '0;
    for (int i = 0; i < n; i++)
      fr.bits[i] = l ? d[n-1-i] : d[i];
    fr.nbits = n;
    fr.cyc = (2 * n + 2) * (int'(dv) + 1);
    for (int i = 0; i < 4; i++)
      fr.cs[i] = (int'(s) == i) ? pol : ~pol;
    fr.cpha = ph;
    return fr;
  endfunction

  // SPI slave monitor: samples sdo on the capture edge.
  logic        m_in = 1'b0, m_prev = 1'b0;
  logic        m_cpol = 1'b0, m_cpha = 1'b0, m_ok = 1'b1;
  logic [31:0] m_bits = '0;
  int          m_n = 0, m_cyc = 0;
  logic [3:0]  m_cs = '0;
  frame_t      m_f;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!m_in && busy) begin
        m_in = 1'b1;
        m_bits = '0;
        m_n = 0;
        m_cyc = 0;
        m_cs = cs_no;
        m_ok = 1'b1;
        m_prev = sclk;
        m_cpol = sclk;
        m_cpha = (exp_q.size() > 0) ? exp_q[0].cpha : 1'b0;
      end
      if (m_in && busy) begin
        m_cyc++;
        if (cs_no !== m_cs) m_ok = 1'b0;
        if (sclk !== m_prev) begin
          if ((sclk !== m_cpol) == (m_cpha == 1'b0)) begin
            m_bits = {m_bits[30:0], sdo};
            m_n++;
          end
          m_prev = sclk;
        end
      end else if (m_in && !busy) begin
        m_in = 1'b0;
        if (skip_next) begin
          skip_next = 1'b0;
        end else if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_frame: got %0d bits, want none",
                   m_n);
        end else begin
          m_f = exp_q.pop_front();
          chk("frame_bits", m_bits, m_f.bits);
          chk("frame_nbits", m_n, m_f.nbits);
          chk("frame_cycles", m_cyc, m_f.cyc);
          chk("frame_cs", m_cs, m_f.cs);
          chk("frame_cs_stable", m_ok, 1);
        end
      end
    end
  end

  task automatic push(input logic [31:0] d);
    @(negedge clk);
    tvalid = 1'b1;
    tdata = d;
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic pulse_sync();
    @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int i;
    i = 0;
    while (busy && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk({nm, "_done"}, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    @(negedge clk);
    en = 1'b1;
    cpol = v.cpol;
    cpha = v.cpha;
    lsb = v.lsb;
    dff = v.dff;
    div = v.div;
    sspol = v.sspol;
    cs_sel = v.cs;
    push(v.data);
    chk($sformatf("vec%0d_fill1", k), fill, 1);
    exp_q.push_back(mk_frame(v.data, v.dff, v.div, v.lsb,
                             v.sspol, v.cs, v.cpha));
    pulse_sync();
    chk($sformatf("vec%0d_busy", k), busy, 1);
    wait_idle($sformatf("vec%0d", k), 6000);
    chk($sformatf("vec%0d_fill0", k), fill, 0);
    chk($sformatf("vec%0d_idle_sclk", k), sclk, v.cpol);
    chk($sformatf("vec%0d_idle_cs", k), cs_no, {4{~v.sspol}});
  endtask

  logic [31:0] words [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  initial begin
    vec_t tbl [7];
    tbl[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd1,   1'b0, 3'd2, 32'h0000_00A5};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 2'd1, 8'd0,   1'b0, 3'd0, 32'h0000_1234};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 2'd2, 8'd2,   1'b0, 3'd1, 32'hFFC3_5A69};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 2'd3, 8'd0,   1'b0, 3'd3, 32'h8000_0003};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 2'd3, 8'd3,   1'b0, 3'd0, 32'hDEAD_BEEF};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 2'd0, 8'd0,   1'b1, 3'd5, 32'h0000_003C};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd255, 1'b0, 3'd1, 32'h0000_0096};

    repeat (2) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_cs", cs_no, 4'hF);
    chk("rst_sdo", sdo, 0);
    chk("rst_tready", tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fill", fill, 0);
    chk("rst_uflow", uflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 7; k++) run_vec(tbl[k], k);

    // FIFO full, then drain and underflow.
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
    dff = 2'd0; div = 8'd0; sspol = 1'b0; cs_sel = 3'd0;
    for (int i = 0; i < 4; i++) push(words[i]);
    chk("full_fill", fill, 4);
    chk("full_tready", tready, 0);
    tvalid = 1'b1;
    tdata = 32'h55;
    repeat (2) @(negedge clk);
    tvalid = 1'b0;
    chk("full_fill_hold", fill, 4);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk_frame(words[i], 2'd0, 8'd0,
                               1'b0, 1'b0, 3'd0, 1'b0));
      pulse_sync();
      wait_idle($sformatf("fifo%0d", i), 1000);
    end
    chk("drain_fill", fill, 0);
    chk("uflow_pre", uflow, 0);
    pulse_sync();
    chk("uflow_no_frame", busy, 0);
    chk("uflow_set", uflow, 1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("uflow_clr", uflow, 0);
    sync = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    clr = 1'b0;
    chk("uflow_clr_prio", uflow, 0);

    // Abort mid-frame by dropping the enable.
    @(negedge clk);
    cpol = 1'b1; cpha = 1'b0; dff = 2'd3;
    div = 8'd1; cs_sel = 3'd1;
    push(32'hCAFE_F00D);
    push(32'h1);
    push(32'h2);
    chk("abort_fill_pre", fill, 3);
    skip_next = 1'b1;
    pulse_sync();
    repeat (16) @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    en = 1'b0;
    @(negedge clk);
    chk("abort_cs", cs_no, 4'hF);
    chk("abort_sclk", sclk, 1);
    chk("abort_busy", busy, 0);
    chk("abort_fill", fill, 0);
    chk("abort_tready", tready, 0);
    chk("abort_sdo", sdo, 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_fill_after", fill, 0);

    // Sync while busy plus a divider change mid-frame.
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; dff = 2'd0;
    div = 8'd1; cs_sel = 3'd2; sspol = 1'b0;
    push(32'h5A);
    push(32'hC3);
    exp_q.push_back(mk_frame(32'h5A, 2'd0, 8'd1,
                             1'b0, 1'b0, 3'd2, 1'b0));
    pulse_sync();
    repeat (10) @(negedge clk);
    sync = 1'b1;
    div = 8'd3;
    @(negedge clk);
    sync = 1'b0;
    wait_idle("mid1", 1000);
    chk("mid_fill", fill, 1);
    exp_q.push_back(mk_frame(32'hC3, 2'd0, 8'd3,
                             1'b0, 1'b0, 3'd2, 1'b0));
    pulse_sync();
    wait_idle("mid2", 1000);
    chk("mid_fill_end", fill, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/wfg_drive_spi_mc.md
Name: wfg_drive_spi_mc

Overview:
Parametrised multi-chip-select SPI master drive core for the waveform generator, replacing the single-CS, fixed-format SPI driver core.
- Buffers AXI-Stream samples in an internal FIFO.
- On each pattern sync pulse, shifts one frame out to one of NUM_CS slaves.
- Frame length, clock mode, bit order and slave-select polarity are all configurable.
- Sits between the pattern/stream fabric and the chip SPI pads; its register-bank wrapper drives the cfg/ctrl inputs.

Parameters:
AXIS_DATA_WIDTH, 32, stream word width; must be ≥ 8.
NUM_CS, 4, number of chip-select outputs (1..8).
FIFO_DEPTH, 4, sample FIFO entries; must be a power of two, ≥ 2.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wfg_pat_sync_i  in  1  single-cycle transfer trigger
wfg_axis_tready_o  out  1  stream ready
wfg_axis_tvalid_i  in  1  stream valid
wfg_axis_tdata_i  in  AXIS_DATA_WIDTH  sample
wfg_axis_tlast_i  in  1  ignored
ctrl_en_q_i  in  1  core enable
clkcfg_div_q_i  in  8  SCLK half-period = div+1 clk cycles
cfg_cpol_q_i  in  1  SCLK idle level
cfg_cpha_q_i  in  1  clock phase
cfg_lsbfirst_q_i  in  1  1 = LSB first
cfg_dff_q_i  in  2  frame length 0:8, 1:16, 2:24, 3:32 bits
cfg_sspol_q_i  in  1  1 = CS active-high
cfg_cs_sel_q_i  in  3  target CS index
status_clr_i  in  1  clears sticky flags
wfg_drive_spi_sclk_o  out  1  SPI clock
wfg_drive_spi_cs_no  out  NUM_CS  chip selects
wfg_drive_spi_sdo_o  out  1  data out
status_busy_o  out  1  transfer in progress
status_fill_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
status_uflow_o  out  1  sticky: sync seen with FIFO empty

Behaviour:
Reset values:
- sclk = 0; cs_no = all inactive (all 1, because sspol resets to 0 upstream; in general every bit is at the inactive level).
- sdo = 0, tready = 0, busy = 0, fill = 0, uflow = 0.
- FSM in IDLE, FIFO empty.

Outputs while idle:
- sclk = cfg_cpol_q_i.
- All CS bits = !cfg_sspol_q_i.

Stream/FIFO:
- tready = ctrl_en_q_i && !full.
- A word is written on tvalid && tready.
- Pop happens only on the IDLE→SETUP transition.
- Simultaneous push and pop keeps fill unchanged; it is legal when full because the pop frees the slot first is NOT assumed: tready stays low when full.

Frame length:
- N = 8·(dff+1), clamped to AXIS_DATA_WIDTH.
- The frame is tdata[N-1:0]; upper bits are discarded.

FSM, with H = div+1 clk cycles:
- IDLE: on wfg_pat_sync_i && ctrl_en_q_i && !empty:
  - pop the FIFO and load the shift register;
  - drive CS[cfg_cs_sel_q_i] active; busy = 1;
  - go to SETUP on the next cycle.
  - If cfg_cs_sel_q_i ≥ NUM_CS, the word is popped and the frame still runs, but no CS is asserted.
- SETUP: lasts H cycles.
  - CPHA = 0: first bit is on sdo from SETUP entry.
- SHIFT: sclk toggles every H cycles, 2N toggles in total.
  - CPHA = 0: sdo advances on each trailing edge (even toggles), except after the last bit.
  - CPHA = 1: sdo advances on each leading edge; the first bit is presented at the first toggle.
  - Bit order is MSB first; cfg_lsbfirst_q_i = 1 gives LSB first.
- HOLD: H cycles with sclk at CPOL, then CS inactive, busy = 0, return to IDLE.
- Total CS-active time = (2N+2)·H cycles.

Configuration timing:
- cfg_cpol, cpha, dff, lsbfirst, sspol, cs_sel and div are sampled into shadow registers at IDLE exit.
- Changes during a frame do not affect that frame.

Boundary cases:
- Sync while busy: ignored, no flag.
- Sync in IDLE with the FIFO empty and enabled: status_uflow_o is set.
- status_clr_i has priority over a simultaneous set.
- ctrl_en_q_i falling mid-frame: on the next cycle the FSM goes to IDLE, CS goes inactive, sclk = CPOL, sdo = 0, the FIFO is flushed (fill = 0) and busy = 0. There is no partial-frame completion.
- div = 0: sclk = clk/2.
- div = 255: H = 256.

Optional Feature:
WFG_DRIVE_SPI_MC_BURST_EN
- Defined:
  - Adds input cfg_burst_q_i (1 bit).
  - When 1, at HOLD end the core goes straight to SETUP if the FIFO is non-empty: CS stays active, a new word is popped, and no sync is needed.
  - The burst ends when the FIFO is empty or ctrl_en falls.
- Undefined: the port is absent and every frame requires its own sync pulse.

Test Plan:
- Mode 0, MSB first, 8-bit: div = 1, CPOL/CPHA = 0, cs_sel = 2; push 0xA5, pulse sync → cs_no = 4'b1011 for 36 cycles; sdo on the 8 rising edges = 1,0,1,0,0,1,0,1; busy high for the same window; fill 1→0.
- Mode 3, LSB first, 16-bit: CPOL = 1, CPHA = 1, lsbfirst = 1, dff = 1, div = 0; push 0x00001234 → 16 sampled bits = 0x1234 bit-reversed order (LSB first); sclk idles high; CS active for 34 cycles.
- FIFO full and underflow: with FIFO_DEPTH = 4 and no sync, push 5 words → tready low after the 4th, fill = 4. Then 5 syncs spaced > frame length → 4 frames sent, uflow = 1 after the 5th. status_clr_i → uflow = 0.
- Abort: ctrl_en dropped at bit 3 of a 32-bit frame with 2 words queued → next cycle all CS inactive, sclk = CPOL, busy = 0, fill = 0, tready = 0.
- Sync during busy and config change mid-frame: sync pulse and div change 1→3 mid-frame → no extra frame, current frame timing unchanged, the next frame uses H = 4.
- Active-high SS, out-of-range CS: sspol = 1, cs_sel = 5 with NUM_CS = 4 → frame clocks out on sclk/sdo, cs_no stays 4'b0000, fill decrements.
